// File: rtl/alu_hex_display.sv
// Shows a captured ALU result byte on a seven-segment digit as a repeating
// high-nibble / low-nibble / blank sequence. Each phase lasts DWELL enabled cycles.
module alu_hex_display #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] result_in,
  input  logic       load,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic       busy
);

  localparam int unsigned CW = $clog2(DWELL);
  localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SHOW_HI = 2'd1;
  localparam logic [1:0] SHOW_LO = 2'd2;
  localparam logic [1:0] GAP     = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    cap_q, cap_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          busy_q, busy_d;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  // load wins over the phase advance, so it is tested first
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    if (ena) begin
      if (load) begin
        cap_d   = result_in;
        state_d = SHOW_HI;
        cnt_d   = RELOAD;
      end else if (state_q != IDLE) begin
        if (cnt_q == '0) begin
          cnt_d = RELOAD;
          case (state_q)
            SHOW_HI: state_d = SHOW_LO;
            SHOW_LO: state_d = GAP;
            default: state_d = SHOW_HI;
          endcase
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    end
  end

  // Outputs decoded from next state so they land on the same edge as the state
  always_comb begin
    seg_d  = 7'h00;
    dp_d   = 1'b0;
    busy_d = (state_d != IDLE);
    case (state_d)
      SHOW_HI: begin seg_d = glyph(cap_d[7:4]); dp_d = 1'b1; end
      SHOW_LO: seg_d = glyph(cap_d[3:0]);
      default: seg_d = 7'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= 8'h00;
      seg_q   <= 7'h00;
      dp_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      busy_q  <= busy_d;
    end
  end

  assign seg_out = seg_q;
  assign dp_out  = dp_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_alu_hex_display.sv
// Scoreboard bench: the driver models the display as "cycles elapsed since the
// last load" and queues expected outputs; a negedge monitor pops and compares.
module tb_alu_hex_display;
  localparam int unsigned DWELL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] result_in = 8'h00;
  logic       load = 1'b0;
  logic [6:0] seg_out;
  logic       dp_out;
  logic       busy;

  alu_hex_display #(.DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .result_in(result_in),
    .load(load), .seg_out(seg_out), .dp_out(dp_out), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [6:0] GLY [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int nvec = 0;
  int nerr = 0;

  bit       m_loaded = 1'b0;
  bit [7:0] m_val = 8'h00;
  int       m_t = 0;

  logic [8:0] expq [$];

  function automatic logic [8:0] model_out();
    int ph;
    if (!m_loaded) return 9'h000;
    ph = (m_t / DWELL) % 3;
    if (ph == 0) return {GLY[m_val[7:4]], 1'b1, 1'b1};
    if (ph == 1) return {GLY[m_val[3:0]], 1'b0, 1'b1};
    return {7'h00, 1'b0, 1'b1};
  endfunction

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s t=%0t got seg=%02h dp=%0b busy=%0b want seg=%02h dp=%0b busy=%0b",
               name, $time, got[8:2], got[1], got[0], exp[8:2], exp[1], exp[0]);
    end
  endtask

  // One clock: inputs set now, model advanced at the edge, expectation queued
  task automatic cycle(input logic e, input logic l, input logic [7:0] r);
    ena = e; load = l; result_in = r;
    @(posedge clk);
    if (rst_n && e) begin
      if (l) begin m_loaded = 1'b1; m_val = r; m_t = 0; end
      else if (m_loaded) m_t++;
    end
    expq.push_back(model_out());
    #1;
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'($urandom));
  endtask

  // Asserted between edges; outputs must clear without a clock
  task automatic async_reset(input int hold);
    @(negedge clk); #1;
    rst_n = 1'b0;
    m_loaded = 1'b0; m_t = 0; m_val = 8'h00;
    #1;
    check("async_reset", {seg_out, dp_out, busy}, 9'h000);
    for (int i = 0; i < hold; i++) cycle(1'b1, 1'($urandom), 8'($urandom));
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) check("scoreboard", {seg_out, dp_out, busy}, expq.pop_front());
  end

  initial begin
    #2;
    check("reset_state", {seg_out, dp_out, busy}, 9'h000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(3);

    // A5 walk through all three phases and back to the high glyph
    cycle(1'b1, 1'b1, 8'hA5);
    run(3 * DWELL + 2);

    // result_in changes without load must not reach the display
    cycle(1'b1, 1'b1, 8'h0F);
    for (int i = 0; i < 3 * DWELL; i++) cycle(1'b1, 1'b0, 8'h33);

    // Reload in the 2nd cycle of SHOW_LO restarts from the new high nibble
    cycle(1'b1, 1'b1, 8'h12);
    run(DWELL + 1);
    cycle(1'b1, 1'b1, 8'h9C);
    run(DWELL + 2);

    // Freeze with a pulsed load in the 2nd cycle of SHOW_HI
    cycle(1'b1, 1'b1, 8'h5A);
    run(1);
    for (int i = 0; i < 10; i++) cycle(1'b0, (i == 4), 8'hE7);
    run(2 * DWELL);

    // Async reset in SHOW_LO, then idle until a load coincides with first edge
    cycle(1'b1, 1'b1, 8'hC3);
    run(DWELL + 1);
    async_reset(2);
    run(5);
    async_reset(1);
    cycle(1'b1, 1'b1, 8'h7E);
    run(DWELL);

    // Every byte: both glyphs
    for (int v = 0; v < 256; v++) begin
      cycle(1'b1, 1'b1, 8'(v));
      run(2 * DWELL - 1);
    end

    // Random mix of enable, load, data and resets
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) async_reset($urandom_range(0, 2));
      else cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 14) == 0), 8'($urandom));
    end

    @(posedge clk); @(posedge clk);
    if (expq.size() != 0) begin
      nerr++;
      $display("FAIL drain %0d expectations left, want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
